// File: rtl/addsub_regfile_sequencer.sv
// addsub_regfile_sequencer
//   Initiator side of the register-file port for add/sub instructions.
//   Accepts one instruction over instrValid/instrReady, reads both operands
//   from the register file, computes A+B or A-B and writes the result back.
//   One instruction every 4 cycles: IDLE -> READ -> EXEC -> WRITE -> IDLE.
//
// Optional feature macro: ADDSUB_FLAGS_EN
//   defined   : carry/overflow/zero registered in EXEC, held until next EXEC
//   undefined : carry/overflow/zero tied to 0
//
// Ports
//   clk, reset                         clock, async active-high reset
//   instrValid/instrReady              instruction handshake
//   opSub, instrDest, instrSrcA/B      instruction fields (0=add, 1=sub)
//   srcRegA/B, outBusA/B               register-file read address / data
//   destReg, writeData, regWrite       register-file write port
//   done                               one-cycle pulse with the writeback
//   carry, overflow, zero              result flags
module addsub_regfile_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instrValid,
  output logic                  instrReady,
  input  logic                  opSub,
  input  logic [ADDR_WIDTH-1:0] instrDest,
  input  logic [ADDR_WIDTH-1:0] instrSrcA,
  input  logic [ADDR_WIDTH-1:0] instrSrcB,
  output logic [ADDR_WIDTH-1:0] srcRegA,
  output logic [ADDR_WIDTH-1:0] srcRegB,
  input  logic [DATA_WIDTH-1:0] outBusA,
  input  logic [DATA_WIDTH-1:0] outBusB,
  output logic [ADDR_WIDTH-1:0] destReg,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  regWrite,
  output logic                  done,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  state_t                r_state, w_next;
  logic                  r_op;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [DATA_WIDTH-1:0] r_opA, r_opB;
  logic [DATA_WIDTH-1:0] w_bOp;
  logic [DATA_WIDTH-1:0] w_res;

  // Subtract is A + ~B + 1: the +1 is the carry-in, so it is just r_op.
  assign w_bOp = r_op ? ~r_opB : r_opB;

`ifdef ADDSUB_FLAGS_EN
  logic [DATA_WIDTH:0] w_sum;
  logic                r_carry, r_ovf, r_zero;

  assign w_sum = {1'b0, r_opA} + {1'b0, w_bOp} + {{DATA_WIDTH{1'b0}}, r_op};
  assign w_res = w_sum[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_carry <= w_sum[DATA_WIDTH];
      // Signed overflow: same-sign inputs, result sign differs.
      r_ovf   <= (r_opA[DATA_WIDTH-1] == w_bOp[DATA_WIDTH-1]) &&
                 (w_res[DATA_WIDTH-1] != r_opA[DATA_WIDTH-1]);
      r_zero  <= (w_res == '0);
    end
  end

  assign carry    = r_carry;
  assign overflow = r_ovf;
  assign zero     = r_zero;
`else
  assign w_res    = r_opA + w_bOp + {{(DATA_WIDTH-1){1'b0}}, r_op};
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Control outputs decode straight from state, so regWrite falls the
  // instant reset clears the state register.
  always_comb begin
    w_next     = r_state;
    instrReady = 1'b0;
    regWrite   = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        instrReady = 1'b1;
        if (instrValid) w_next = S_READ;
      end
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WRITE;
      S_WRITE: begin
        regWrite = 1'b1;
        done     = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= 1'b0;
      r_dest    <= '0;
      srcRegA   <= '0;
      srcRegB   <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
      destReg   <= '0;
      writeData <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (instrValid) begin
          r_op    <= opSub;
          r_dest  <= instrDest;
          srcRegA <= instrSrcA;
          srcRegB <= instrSrcB;
        end
        // Operands captured before the writeback, so aliased dest uses old values.
        S_READ: begin
          r_opA <= outBusA;
          r_opB <= outBusB;
        end
        S_EXEC: begin
          writeData <= w_res;
          destReg   <= r_dest;
        end
        default: ;
      endcase
    end
  end

endmodule
